// File: rtl/ibex_instr_wb_bridge.sv
// ibex_instr_wb_bridge: Ibex instruction fetch port to pipelined Wishbone read bridge (optional timeout abort via IBEX_INSTR_WB_TIMEOUT_EN)
module ibex_instr_wb_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1
`ifdef IBEX_INSTR_WB_TIMEOUT_EN
        ,
        DRAIN  = 2'd2
`endif
    } state_e;

    localparam logic [1:0] MaxOut     = 2'(MAX_OUTSTANDING);
    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       draining;
    logic       issue;
    logic       resp;
    logic       unused_bits;

`ifdef IBEX_INSTR_WB_TIMEOUT_EN
    logic [7:0] timer_q, timer_d;
    logic       timeout;

    assign draining    = (state_q == DRAIN);
    assign timer_d     = (state_q != ACTIVE || issue || wb_ack_i || wb_err_i) ? 8'd0 : timer_q + 8'd1;
    assign timeout     = (state_q == ACTIVE) && (timer_d == TimeoutVal) && (timer_d != 8'd0);
    assign unused_bits = ^instr_addr_i[1:0];

    // Timer counting idle ACTIVE cycles since the last bus activity
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= 8'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign draining    = 1'b0;
    assign unused_bits = ^{instr_addr_i[1:0], TimeoutVal};
`endif

    // Strobe is purely combinational so a request can be granted in the cycle it appears
    assign wb_stb_o    = instr_req_i && !draining && (cnt_q < MaxOut);
    assign issue       = wb_stb_o && !wb_stall_i;
    assign instr_gnt_o = issue;
    assign wb_cyc_o    = !draining && (wb_stb_o || (cnt_q != 2'd0));
    assign wb_adr_o    = instr_addr_i[31:2];
    assign wb_sel_o    = 4'hF;
    assign wb_we_o     = 1'b0;

    // During an abort every cycle retires one read as an error; otherwise only a real ack/err does
    assign resp           = (cnt_q != 2'd0) && (draining || wb_ack_i || wb_err_i);
    assign instr_rvalid_o = resp;
    assign instr_err_o    = resp && (draining || wb_err_i);
    assign instr_rdata_o  = wb_dat_i;
    assign busy_o         = (state_q != IDLE);

    // Outstanding count and next state
    always_comb begin
        cnt_d   = cnt_q + {1'b0, issue} - {1'b0, resp};
`ifdef IBEX_INSTR_WB_TIMEOUT_EN
        state_d = draining ? ((cnt_d == 2'd0) ? IDLE : DRAIN) :
                  timeout  ? DRAIN :
                  (cnt_d != 2'd0) ? ACTIVE : IDLE;
`else
        state_d = (cnt_d != 2'd0) ? ACTIVE : IDLE;
`endif
    end

    // State and outstanding-count registers; reset discards all in-flight reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/ibex_instr_wb_bridge.md
IBEX_INSTR_WB_BRIDGE -- requirements
Module: ibex_instr_wb_bridge

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, max in-flight Wishbone reads (1..3).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, cycles without ack/err before abort (8-bit).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 instr_req_i  in  1  fetch request from the prefetch stage.
REQ-006 instr_addr_i  in  32  fetch byte address; bits [1:0] ignored.
REQ-007 instr_gnt_o  out  1  request accepted this cycle.
REQ-008 instr_rvalid_o  out  1  response valid.
REQ-009 instr_rdata_o  out  32  response data.
REQ-010 instr_err_o  out  1  response is an error; qualified by instr_rvalid_o.
REQ-011 wb_cyc_o, wb_stb_o  out  1 each  Wishbone pipelined cycle/strobe.
REQ-012 wb_adr_o  out  30  word address; wb_sel_o out 4; wb_we_o out 1.
REQ-013 wb_dat_i  in  32; wb_ack_i, wb_err_i, wb_stall_i  in  1 each.
REQ-014 busy_o  out  1  any transaction in flight or abort in progress.

Function
REQ-015 States: IDLE (0 outstanding), ACTIVE (>=1 outstanding), DRAIN (abort after timeout).
REQ-016 wb_stb_o = instr_req_i AND state!=DRAIN AND outstanding<MAX_OUTSTANDING, combinational.
REQ-017 instr_gnt_o = wb_stb_o AND NOT wb_stall_i; zero-cycle grant latency.
REQ-018 wb_adr_o = instr_addr_i[31:2]; wb_sel_o = 4'hF; wb_we_o = 0 always.
REQ-019 wb_cyc_o = wb_stb_o OR outstanding!=0; deasserted in DRAIN.
REQ-020 Outstanding counter (2 bits): +1 on issue (stb AND NOT stall), -1 on ack OR err while outstanding>0; both same cycle -> unchanged.
REQ-021 instr_rvalid_o = (wb_ack_i OR wb_err_i) AND outstanding>0 AND state!=DRAIN; data from wb_dat_i combinationally, zero added latency.
REQ-022 instr_err_o = wb_err_i under the same qualification; ack and err together -> error response.
REQ-023 Ack/err with outstanding==0 or in DRAIN are discarded, no response, counter unchanged.
REQ-024 Responses are in issue order; no reordering, no buffering.
REQ-025 Transitions: IDLE->ACTIVE on issue; ACTIVE->IDLE when counter reaches 0 with no new issue; ACTIVE->DRAIN on timeout (macro only).
REQ-026 busy_o = state!=IDLE.

Reset
REQ-027 On rst_ni low, immediately: state IDLE, counter 0, timer 0, all Wishbone and instr outputs low except those driven combinationally from inputs per REQ-016/017/021.
REQ-028 Reset mid-transaction abandons outstanding reads; no responses are emitted for them after reset release.

Configuration
REQ-029 Macro IBEX_INSTR_WB_TIMEOUT_EN, when defined, adds an 8-bit timer: cleared on issue, ack or err; increments each ACTIVE cycle otherwise; at TIMEOUT_CYCLES enter DRAIN.
REQ-030 In DRAIN: wb_cyc_o/wb_stb_o low, instr_gnt_o low; emit one instr_rvalid_o+instr_err_o pulse per cycle per outstanding read, decrementing the counter; at 0 return to IDLE.
REQ-031 Macro undefined: no timer, no DRAIN state, TIMEOUT_CYCLES unused; bridge waits indefinitely for ack/err.

Verification
REQ-032 Single fetch addr 0x0000_1004, no stall, ack next cycle, dat 0xDEAD_BEEF -> gnt same cycle, wb_adr_o 0x401, rvalid with rdata 0xDEAD_BEEF one cycle after issue, busy_o low after.
REQ-033 Back-to-back 0x100,0x104,0x108 with MAX_OUTSTANDING=2, acks delayed 3 cycles -> third request not granted until first ack; responses in order; counter never exceeds 2.
REQ-034 wb_stall_i high 4 cycles with instr_req_i high -> gnt low for 4 cycles, stb held, address stable; granted on cycle 5.
REQ-035 wb_err_i on 2nd of 2 outstanding -> first rvalid err=0, second rvalid err=1; spurious ack in IDLE -> no rvalid.
REQ-036 Macro on, TIMEOUT_CYCLES=16, 2 outstanding, no ack -> at 16 idle cycles cyc drops, two consecutive rvalid+err pulses, then IDLE; late ack ignored.
REQ-037 rst_ni asserted with 2 outstanding -> outputs low immediately; ack after release produces no rvalid.
